// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
package exc_pkg;

    localparam int ESTAT_W  = 4;
    localparam int NSRC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } exc_state_e;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the eligible request vector.
module prio_enc
    import exc_pkg::*;
#(
    parameter int N = NSRC_DEF
) (
    input  logic [N-1:0]       req,
    output logic               valid,
    output logic [ESTAT_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Walk from the top so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ESTAT_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: latches requests, takes the highest-priority eligible
// one from IDLE, and sequences REQ -> HANDLER -> IDLE.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int CNTW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    ExcSrc,
    input  logic [NSRC-1:0]    ExcMask,
    input  logic               ExcAck,
    input  logic               ERet,
    output logic               Exc,
    output logic [ESTAT_W-1:0] EStatus,
    output logic               InHandler,
    output logic [NSRC-1:0]    Pending,
    output logic [CNTW-1:0]    ExcCount
);

    exc_state_e         state_q, state_d;
    logic               exc_q, exc_d;
    logic               in_handler_q, in_handler_d;
    logic [ESTAT_W-1:0] estatus_q, estatus_d;
    logic [NSRC-1:0]    pending_q, pending_d;
    logic [CNTW-1:0]    count_q, count_d;

    logic [NSRC-1:0]    eligible;
    logic               enc_valid;
    logic [ESTAT_W-1:0] enc_idx;
    logic               take;
    logic [NSRC-1:0]    take_mask;

    assign eligible = pending_q & ~ExcMask;

    prio_enc #(.N(NSRC)) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        take      = (state_q == IDLE) && enc_valid;
        take_mask = take ? (NSRC'(1) << enc_idx) : '0;

        state_d = state_q;
        case (state_q)
            IDLE:    if (take)   state_d = REQ;
            REQ:     if (ExcAck) state_d = HANDLER;
            HANDLER: if (ERet)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase

        exc_d        = (state_d == REQ);
        in_handler_d = (state_d == HANDLER);

        // A new request on the take cycle re-arms the bit.
        pending_d = (pending_q & ~take_mask) | ExcSrc;
        estatus_d = take ? ESTAT_W'(enc_idx + 4'd1) : estatus_q;

        count_d = count_q;
        if (take && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            exc_q        <= 1'b0;
            in_handler_q <= 1'b0;
            estatus_q    <= '0;
            pending_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            exc_q        <= exc_d;
            in_handler_q <= in_handler_d;
            estatus_q    <= estatus_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
        end
    end

    assign Exc       = exc_q;
    assign InHandler = in_handler_q;
    assign EStatus   = estatus_q;
    assign Pending   = pending_q;
    assign ExcCount  = count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; a 2-bit-counter copy shares the stimulus.
module tb_exc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] exc_src, exc_mask;
    logic       exc_ack, eret;

    logic       exc_a, inh_a, exc_b, inh_b;
    logic [3:0] est_a, est_b, pend_a, pend_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.NSRC(4), .CNTW(8)) dut (
        .clk(clk), .reset(reset), .ExcSrc(exc_src), .ExcMask(exc_mask),
        .ExcAck(exc_ack), .ERet(eret), .Exc(exc_a), .EStatus(est_a),
        .InHandler(inh_a), .Pending(pend_a), .ExcCount(cnt_a)
    );

    exc_ctrl #(.NSRC(4), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .ExcSrc(exc_src), .ExcMask(exc_mask),
        .ExcAck(exc_ack), .ERet(eret), .Exc(exc_b), .EStatus(est_b),
        .InHandler(inh_b), .Pending(pend_b), .ExcCount(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic e, input logic h,
                             input logic [3:0] st, input logic [3:0] p);
        chk({tag, ".Exc"},       32'(exc_a), 32'(e));
        chk({tag, ".InHandler"}, 32'(inh_a), 32'(h));
        chk({tag, ".EStatus"},   32'(est_a), 32'(st));
        chk({tag, ".Pending"},   32'(pend_a), 32'(p));
    endtask

    initial begin
        reset = 1'b1; exc_src = '0; exc_mask = '0; exc_ack = 1'b0; eret = 1'b0;
        tick(); tick();
        chk_state("rst", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("rst.cnt", 32'(cnt_a), 32'd0);
        reset = 1'b0;
        tick();

        // Single source 2 pulse.
        exc_src = 4'b0100; tick(); exc_src = '0;
        chk_state("s2.latch", 1'b0, 1'b0, 4'd0, 4'b0100);
        tick();
        chk_state("s2.take", 1'b1, 1'b0, 4'd3, 4'b0000);
        chk("s2.cnt", 32'(cnt_a), 32'd1);
        tick();
        chk("s2.hold", 32'(exc_a), 32'd1);
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        chk_state("s2.hdl", 1'b0, 1'b1, 4'd3, 4'b0000);
        eret = 1'b1; tick(); eret = 1'b0;
        chk_state("s2.ret", 1'b0, 1'b0, 4'd3, 4'b0000);

        // Simultaneous sources 1 and 3: priority and re-take after ERet.
        exc_src = 4'b1010; tick(); exc_src = '0;
        tick();
        chk_state("pr.take1", 1'b1, 1'b0, 4'd2, 4'b1000);
        chk("pr.cnt", 32'(cnt_a), 32'd2);
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        tick();
        chk_state("pr.hdl_notake", 1'b0, 1'b1, 4'd2, 4'b1000);
        eret = 1'b1; tick(); eret = 1'b0;
        chk_state("pr.idle", 1'b0, 1'b0, 4'd2, 4'b1000);
        tick();
        chk_state("pr.take3", 1'b1, 1'b0, 4'd4, 4'b0000);
        chk("pr.cnt3", 32'(cnt_a), 32'd3);
        chk("pr.cnt3_w2", 32'(cnt_b), 32'd3);
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;

        // Masked source stays pending until unmasked.
        exc_mask = 4'b0001; exc_src = 4'b0001; tick(); exc_src = '0;
        chk_state("mk.latch", 1'b0, 1'b0, 4'd4, 4'b0001);
        tick();
        chk_state("mk.blocked", 1'b0, 1'b0, 4'd4, 4'b0001);
        exc_mask = '0; tick();
        chk_state("mk.take", 1'b1, 1'b0, 4'd1, 4'b0000);
        chk("mk.cnt", 32'(cnt_a), 32'd4);
        chk("mk.sat_w2", 32'(cnt_b), 32'd3);
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;

        // Async reset in HANDLER with requests pending.
        exc_src = 4'b0110; tick(); exc_src = '0;
        chk_state("ar.pre", 1'b0, 1'b1, 4'd1, 4'b0110);
        #2 reset = 1'b1;
        #1;
        chk_state("ar.async", 1'b0, 1'b0, 4'd0, 4'd0);
        chk("ar.cnt", 32'(cnt_a), 32'd0);
        exc_src = 4'b0001; tick();
        chk("ar.no_latch", 32'(pend_a), 32'd0);
        reset = 1'b0; exc_src = '0;
        tick(); tick();
        chk_state("ar.quiet", 1'b0, 1'b0, 4'd0, 4'd0);

        // Stray ERet/ExcAck in IDLE.
        eret = 1'b1; exc_ack = 1'b1; tick(); eret = 1'b0; exc_ack = 1'b0;
        chk_state("st.idle", 1'b0, 1'b0, 4'd0, 4'd0);

        // Five takes: narrow counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            exc_src = 4'b0001; tick(); exc_src = '0;
            tick();
            chk("lp.exc", 32'(exc_a), 32'd1);
            if (k == 0) begin
                eret = 1'b1; exc_mask = 4'b1111; tick(); eret = 1'b0;
                chk_state("lp.req_ign", 1'b1, 1'b0, 4'd1, 4'd0);
                exc_mask = '0;
            end
            exc_ack = 1'b1; tick(); exc_ack = 1'b0;
            eret = 1'b1; tick(); eret = 1'b0;
        end
        chk("lp.cnt8", 32'(cnt_a), 32'd5);
        chk("lp.cnt2", 32'(cnt_b), 32'd3);
        chk("lp.inh", 32'(inh_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of exception sources; legal range 2..15.
REQ-002 Parameter CNTW, default 8: width of the taken-exception counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ExcSrc  input  NSRC  exception request lines; bit 0 has highest priority.
REQ-006 ExcMask  input  NSRC  per-source mask; 1 blocks that source from being taken.
REQ-007 ExcAck  input  1  PC has reached the exception vector (handler entry).
REQ-008 ERet  input  1  handler return instruction executing.
REQ-009 Exc  output  1  exception request to the exception datapath.
REQ-010 EStatus  output  4  cause code of the exception being taken or serviced.
REQ-011 InHandler  output  1  high while the handler runs.
REQ-012 Pending  output  NSRC  latched, not-yet-taken requests.
REQ-013 ExcCount  output  CNTW  number of exceptions taken, saturating.

Function
REQ-014 FSM states SHALL be IDLE, REQ and HANDLER.
REQ-015 Pending[i] SHALL set on any cycle ExcSrc[i]=1, regardless of state or mask.
REQ-016 Pending[i] SHALL clear only on the cycle source i is taken; a simultaneous set SHALL win.
REQ-017 Eligible set = Pending & ~ExcMask.
REQ-018 IDLE with a non-empty eligible set: next state REQ; lowest eligible index i is taken.
REQ-019 On taking source i: EStatus SHALL register 4-bit code i+1, Pending[i] clears, and ExcCount increments.
REQ-020 ExcCount SHALL saturate at all-ones and SHALL NOT wrap.
REQ-021 Exc SHALL be 1 exactly while in REQ, so it rises one cycle after the take decision.
REQ-022 REQ with ExcAck=1: next state HANDLER and Exc drops the following cycle; REQ otherwise holds indefinitely.
REQ-023 InHandler SHALL be 1 exactly while in HANDLER.
REQ-024 HANDLER with ERet=1: next state IDLE; new requests still latch but are not taken.
REQ-025 EStatus SHALL hold its value from take through REQ and HANDLER, and remain stable in IDLE until the next take.
REQ-026 ERet in IDLE or REQ SHALL be ignored.
REQ-027 ExcAck in IDLE or HANDLER SHALL be ignored.
REQ-028 The earliest re-take SHALL be the cycle after returning to IDLE: Exc rises 2 cycles after ERet.
REQ-029 Masking a pending source SHALL keep it pending; unmasking SHALL make it eligible the next IDLE cycle.
REQ-030 ExcMask changes during REQ or HANDLER SHALL NOT alter the cause already taken.

Reset
REQ-031 On reset assertion, state SHALL be IDLE immediately (async), including mid-REQ or mid-HANDLER.
REQ-032 Reset values SHALL be: Exc=0, InHandler=0, EStatus=4'b0000, Pending=0, ExcCount=0.
REQ-033 ExcSrc SHALL NOT set Pending while reset is high.

Structure
REQ-034 Package exc_pkg SHALL hold the state enum, the EStatus code width and the NSRC default.
REQ-035 Sub-module prio_enc (NSRC-bit lowest-index-first encoder: valid, index) SHALL perform selection combinationally.

Verification
REQ-036 ExcSrc=4'b0100 pulse 1 cycle in IDLE -> Exc high cycles 2..k, EStatus=3, ExcCount=1; ExcAck -> InHandler=1, Exc=0.
REQ-037 ExcSrc=4'b1010 same cycle -> source 1 taken (EStatus=2), Pending=4'b1000; after ERet, Exc re-asserts 2 cycles later with EStatus=4.
REQ-038 ExcMask=4'b0001, ExcSrc=4'b0001 -> no Exc, Pending=4'b0001; clear mask -> Exc next cycle+1, EStatus=1.
REQ-039 Reset asserted during HANDLER with Pending=4'b0110 -> immediately IDLE, all outputs zero, no Exc after release.
REQ-040 CNTW=2, take 5 exceptions -> ExcCount stays 3; stray ERet/ExcAck in IDLE -> no state change.
